// File: rtl/fullchip_seq_ctrl.sv
// fullchip_seq_ctrl: tile sequencer for the dual-core attention chip.
// One accepted start produces the whole per-tile instruction stream:
// K/Q writes, K load, execute, array drain wait, output-FIFO drain to psum
// memory, then a five-step normalisation per Q row.
// Handshake: start is a level sampled only in IDLE (one tile per accept);
// ofifo_valid is sampled only once the WAIT minimum has elapsed.
// All outputs are registered and decoded from the next state.
// Optional feature macro: FULLCHIP_SEQ_CTRL_PERF_EN adds perf_cycles.
module fullchip_seq_ctrl #(
  parameter int COL      = 8,
  parameter int N_Q      = 8,
  parameter int WAIT_CYC = 16,
  parameter int CW       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic        busy,
  output logic        done,
  output logic        data_req,
  output logic        core1_en,
  output logic        core2_en,
  output logic [16:0] inst,
  output logic        acc,
  output logic        div,
  output logic        wr_norm,
  output logic        fifo_ext_rd
`ifdef FULLCHIP_SEQ_CTRL_PERF_EN
  ,
  output logic [15:0] perf_cycles
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_K_WR, S_Q_WR, S_K_LOAD, S_GAP,
    S_EXEC, S_WAIT, S_DRAIN, S_NORM, S_DONE
  } state_t;

  localparam logic [CW-1:0] COL_LAST  = CW'(COL - 1);
  localparam logic [CW-1:0] NQ_LAST   = CW'(N_Q - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;      // cycle count in phase; row index in NORM
  logic [2:0]    step_q, step_d;    // NORM substep 0..4

  logic        busy_q, busy_d, done_q, done_d, dreq_q, dreq_d;
  logic [16:0] inst_q, inst_d;
  logic        acc_q, acc_d, div_q, div_d, wrn_q, wrn_d, fxr_q, fxr_d;

  // Next-state logic: counters restart at 0 on every phase change
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    step_d  = 3'd0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_K_WR;
      end
      S_K_WR:   if (cnt_q == COL_LAST) begin state_d = S_Q_WR;   cnt_d = '0; end
      S_Q_WR:   if (cnt_q == NQ_LAST)  begin state_d = S_K_LOAD; cnt_d = '0; end
      S_K_LOAD: if (cnt_q == COL_LAST) begin state_d = S_GAP;    cnt_d = '0; end
      S_GAP: begin
        state_d = S_EXEC;
        cnt_d   = '0;
      end
      S_EXEC:   if (cnt_q == NQ_LAST)  begin state_d = S_WAIT;   cnt_d = '0; end
      S_WAIT: begin
        if (cnt_q >= WAIT_LAST && ofifo_valid) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d = cnt_q;   // saturate while stalled on a late ofifo_valid
        end
      end
      S_DRAIN:  if (cnt_q == NQ_LAST)  begin state_d = S_NORM;   cnt_d = '0; end
      S_NORM: begin
        if (step_q == 3'd4) begin
          if (cnt_q == NQ_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end else begin
          step_d = step_q + 3'd1;
          cnt_d  = cnt_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so outputs line up with their state
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    dreq_d = (state_d == S_K_WR) || (state_d == S_Q_WR);
    inst_d = '0;
    acc_d  = 1'b0;
    div_d  = 1'b0;
    wrn_d  = 1'b0;
    fxr_d  = 1'b0;
    case (state_d)
      S_K_WR:   begin inst_d[14] = 1'b1; inst_d[6:3] = cnt_d[3:0]; end
      S_Q_WR:   begin inst_d[12] = 1'b1; inst_d[6:3] = cnt_d[3:0]; end
      S_K_LOAD: begin inst_d[13] = 1'b1; inst_d[1] = 1'b1; inst_d[6:3] = cnt_d[3:0]; end
      S_EXEC:   begin inst_d[11] = 1'b1; inst_d[0] = 1'b1; inst_d[6:3] = cnt_d[3:0]; end
      S_DRAIN:  begin inst_d[2] = 1'b1; inst_d[16] = 1'b1; inst_d[10:7] = cnt_d[3:0]; end
      S_NORM: begin
        case (step_d)
          3'd0:    begin inst_d[15] = 1'b1; inst_d[10:7] = cnt_d[3:0]; end
          3'd1:    acc_d = 1'b1;
          3'd2:    fxr_d = 1'b1;
          3'd3:    div_d = 1'b1;
          default: wrn_d = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dreq_q  <= 1'b0;
      inst_q  <= '0;
      acc_q   <= 1'b0;
      div_q   <= 1'b0;
      wrn_q   <= 1'b0;
      fxr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dreq_q  <= dreq_d;
      inst_q  <= inst_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      wrn_q   <= wrn_d;
      fxr_q   <= fxr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign data_req    = dreq_q;
  assign core1_en    = busy_q;
  assign core2_en    = busy_q;
  assign inst        = inst_q;
  assign acc         = acc_q;
  assign div         = div_q;
  assign wr_norm     = wrn_q;
  assign fifo_ext_rd = fxr_q;

`ifdef FULLCHIP_SEQ_CTRL_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Busy-cycle counter: cleared on accept, saturating, held in IDLE
  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE) begin
      if (start) perf_d = 16'd0;
    end else if (perf_q != 16'hFFFF) begin
      perf_d = perf_q + 16'd1;
    end
  end

  // Performance counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_q <= 16'd0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_fullchip_seq_ctrl.sv
// Bench for fullchip_seq_ctrl: a tile-position model predicts every output
// each cycle; directed scenarios pin tile length and strobe counts.
module tb_fullchip_seq_ctrl;
  localparam int COL      = 8;
  localparam int N_Q      = 8;
  localparam int WAIT_CYC = 16;
  localparam int PRE      = 2 * COL + 2 * N_Q + 1;   // cycles before WAIT
  localparam int W        = 26;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic ofifo_valid = 1'b1;
  always #5 clk = ~clk;

  logic        busy, done, data_req, core1_en, core2_en;
  logic [16:0] inst;
  logic        acc, div, wr_norm, fifo_ext_rd;
`ifdef FULLCHIP_SEQ_CTRL_PERF_EN
  logic [15:0] perf_cycles;
`endif

  fullchip_seq_ctrl #(.COL(COL), .N_Q(N_Q), .WAIT_CYC(WAIT_CYC), .CW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .busy(busy), .done(done), .data_req(data_req),
    .core1_en(core1_en), .core2_en(core2_en), .inst(inst),
    .acc(acc), .div(div), .wr_norm(wr_norm), .fifo_ext_rd(fifo_ext_rd)
`ifdef FULLCHIP_SEQ_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [W-1:0] dut_vec;
  assign dut_vec = {busy, done, data_req, core1_en, core2_en, inst,
                    acc, div, wr_norm, fifo_ext_rd};

  // ---------------- behavioural model ----------------
  // Expected outputs for busy-cycle t (0-based) of a tile.
  function automatic logic [W-1:0] model_vec(int t, bit wk, int wlen);
    logic [16:0] in;
    logic dn, dq, ac, dv, wn, fx;
    int p, n;
    in = '0; dn = 0; dq = 0; ac = 0; dv = 0; wn = 0; fx = 0;
    if (t < COL) begin
      in[14] = 1; p = t; in[6:3] = p[3:0]; dq = 1;
    end else if (t < COL + N_Q) begin
      in[12] = 1; p = t - COL; in[6:3] = p[3:0]; dq = 1;
    end else if (t < 2 * COL + N_Q) begin
      in[13] = 1; in[1] = 1; p = t - COL - N_Q; in[6:3] = p[3:0];
    end else if (t == 2 * COL + N_Q) begin
      in = '0;
    end else if (t < PRE) begin
      in[11] = 1; in[0] = 1; p = t - (2 * COL + N_Q + 1); in[6:3] = p[3:0];
    end else if (!wk || t < PRE + wlen) begin
      in = '0;
    end else begin
      p = t - PRE - wlen;
      if (p < N_Q) begin
        in[2] = 1; in[16] = 1; in[10:7] = p[3:0];
      end else if (p < 6 * N_Q) begin
        n = (p - N_Q) / 5;
        case ((p - N_Q) % 5)
          0: begin in[15] = 1; in[10:7] = n[3:0]; end
          1: ac = 1;
          2: fx = 1;
          3: dv = 1;
          default: wn = 1;
        endcase
      end else begin
        dn = 1;
      end
    end
    return {1'b1, dn, dq, 1'b1, 1'b1, in, ac, dv, wn, fx};
  endfunction

  logic [W-1:0] exp_q[$];
  bit m_act = 0;
  bit m_wk = 0;
  int m_t = 0;
  int m_wlen = 0;

  // Model advances on the same edges as the DUT and queues its expectation
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1; m_t = 0; m_wk = 0; m_wlen = 0;
      end
    end else begin
      if (!m_wk && m_t >= PRE && (m_t - PRE) >= WAIT_CYC - 1 && ofifo_valid) begin
        m_wk = 1;
        m_wlen = m_t - PRE + 1;
      end
      if (m_wk && m_t == PRE + m_wlen + 6 * N_Q) m_act = 0;
      else m_t++;
    end
    exp_q.delete();
    exp_q.push_back(m_act ? model_vec(m_t, m_wk, m_wlen) : '0);
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        failures++;
        $display("FAIL out_vec t=%0d got=%h exp=%h", m_t, dut_vec, e);
      end
    end
  end

  // Strobe counters for the literal pins
  int busy_cnt, done_cnt, done_at, kw_cnt, kw_first, ex_cnt;
  int acc_cnt, div_cnt, wn_cnt, fx_cnt;
  always @(negedge clk) begin
    if (busy) begin
      busy_cnt++;
      if (done) begin done_cnt++; done_at = busy_cnt; end
      if (inst[14]) begin kw_cnt++; if (kw_first == 0) kw_first = busy_cnt; end
      if (inst[0]) ex_cnt++;
      if (acc) acc_cnt++;
      if (div) div_cnt++;
      if (wr_norm) wn_cnt++;
      if (fifo_ext_rd) fx_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clr_counts();
    busy_cnt = 0; done_cnt = 0; done_at = 0; kw_cnt = 0; kw_first = 0;
    ex_cnt = 0; acc_cnt = 0; div_cnt = 0; wn_cnt = 0; fx_cnt = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    chk("idle_timeout", int'(ok), 1);
  endtask

  // Pulse start for one cycle; counters cleared before acceptance
  task automatic pulse_start();
    @(negedge clk);
    clr_counts();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr_counts();
    repeat (3) @(negedge clk);
    reset = 0;

    // Idle with start low
    repeat (20) @(negedge clk);
    chk("idle_busy_cnt", busy_cnt, 0);
    chk("idle_done_cnt", done_cnt, 0);

    // Default tile, ofifo_valid tied high
    ofifo_valid = 1;
    pulse_start();
    wait_idle(200);
    chk("t1_busy_len", busy_cnt, 98);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_at", done_at, 98);
    chk("t1_kw_cnt", kw_cnt, 8);
    chk("t1_kw_first", kw_first, 1);
    chk("t1_exec_cnt", ex_cnt, 8);
    chk("t1_acc_cnt", acc_cnt, 8);
    chk("t1_fx_cnt", fx_cnt, 8);
    chk("t1_div_cnt", div_cnt, 8);
    chk("t1_wn_cnt", wn_cnt, 8);
`ifdef FULLCHIP_SEQ_CTRL_PERF_EN
    chk("t1_perf", int'(perf_cycles), 98);
    repeat (5) @(negedge clk);
    chk("t1_perf_hold", int'(perf_cycles), 98);
`endif

    // Late ofifo_valid: rises on the 40th WAIT cycle
    ofifo_valid = 0;
    pulse_start();
    repeat (72) @(negedge clk);
    ofifo_valid = 1;
    wait_idle(200);
    chk("t2_busy_len", busy_cnt, 98 + 24);
    chk("t2_done_cnt", done_cnt, 1);
`ifdef FULLCHIP_SEQ_CTRL_PERF_EN
    chk("t2_perf", int'(perf_cycles), 122);
`endif

    // Reset during NORM row 3
    pulse_start();
    repeat (73) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("rst_outputs", int'(dut_vec), 0);
    chk("rst_done_cnt", done_cnt, 0);
`ifdef FULLCHIP_SEQ_CTRL_PERF_EN
    chk("rst_perf", int'(perf_cycles), 0);
`endif
    repeat (2) @(negedge clk);
    reset = 0;
    pulse_start();
    wait_idle(200);
    chk("t3_busy_len", busy_cnt, 98);
    chk("t3_done_cnt", done_cnt, 1);

    // start re-pulsed in EXEC and in DONE: ignored
    pulse_start();
    repeat (28) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (68) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    chk("t4_busy_len", busy_cnt, 98);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_idle_after", int'(busy), 0);

    // Randomized start / ofifo_valid traffic against the model
    for (int it = 0; it < 8; it++) begin
      int len;
      len = $urandom_range(150, 260);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        start = ($urandom_range(0, 15) == 0);
        ofifo_valid = ($urandom_range(0, 2) != 0);
      end
      start = 0;
      ofifo_valid = 1;
      wait_idle(300);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fullchip_seq_ctrl.md
Name: fullchip_seq_ctrl

Overview:
- Sequencer for the dual-core attention chip.
- Turns one `start` pulse into the full per-tile instruction stream: K/Q memory writes, K load, execute, output-FIFO drain to psum memory, then per-row normalisation with cross-core sum exchange.
- Drives the chip-level `inst[16:0]`, `acc`, `div`, `wr_norm`, `fifo_ext_rd` and the two core clock-enable lines.
- Sits between the host/testbench and the chip top.

Parameters:
- COL, 8, array columns = K rows loaded per tile
- N_Q, 8, Q rows per tile (1..16; limited by 4-bit addresses)
- WAIT_CYC, 16, minimum array drain cycles after the last execute
- CW, 5, internal counter width (must hold max(COL, N_Q, WAIT_CYC))

Ports:
- clk  input  1  clock; single domain
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  begin one tile; sampled only in IDLE
- ofifo_valid  input  1  output FIFOs of both cores hold a full tile
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse in the DONE state
- data_req  output  1  host must present the `mem_in` row this cycle (K_WR, Q_WR)
- core1_en  output  1  core-1 clock enable
- core2_en  output  1  core-2 clock enable
- inst  output  17  instruction word
- acc  output  1  sum-accumulate strobe
- div  output  1  divide strobe
- wr_norm  output  1  normalised-write strobe
- fifo_ext_rd  output  1  partner-sum FIFO read

Behaviour:
- inst field map:
  - [16] pmem_wr, [15] pmem_rd, [14] kmem_wr, [13] kmem_rd, [12] qmem_wr, [11] qmem_rd
  - [10:7] pmem_add, [6:3] qkmem_add
  - [2] ofifo_rd, [1] load, [0] execute
- All outputs are registered and decoded from the next state, so they are valid in the same cycle as the state they belong to.
- Reset values: every output 0 and state IDLE, applied immediately on reset assertion. Reset mid-operation abandons the tile; no partial `done`.
- IDLE:
  - all strobes 0; core1_en = core2_en = 0
  - start=1 → K_WR
- core1_en and core2_en are 1 in every non-IDLE state.
- K_WR (COL cycles): kmem_wr=1, data_req=1, qkmem_add=cnt (0..COL-1) → Q_WR.
- Q_WR (N_Q cycles): qmem_wr=1, data_req=1, qkmem_add=cnt → K_LOAD.
- K_LOAD (COL cycles): kmem_rd=1, load=1, qkmem_add=cnt → GAP.
- GAP (1 cycle): all inst bits 0 → EXEC.
- EXEC (N_Q cycles): qmem_rd=1, execute=1, qkmem_add=cnt → WAIT.
- WAIT:
  - inst all 0; counts up from 0
  - exits when cnt ≥ WAIT_CYC-1 and ofifo_valid=1
  - cnt saturates, so a late ofifo_valid stalls here indefinitely
- DRAIN (N_Q cycles): ofifo_rd=1, pmem_wr=1, pmem_add=cnt → NORM.
- NORM: for row r = 0..N_Q-1, a 5-cycle substep sequence; only the listed strobe is high in each step:
  - S0: pmem_rd=1, pmem_add=r
  - S1: acc=1
  - S2: fifo_ext_rd=1
  - S3: div=1
  - S4: wr_norm=1
  - After S4 of row N_Q-1 → DONE.
- DONE (1 cycle): done=1, busy=1 → IDLE.
- start is ignored while busy.
- start asserted in the same cycle as DONE is ignored. A new tile needs start in IDLE.
- Counters reset to 0 on every state transition. Address fields are the low 4 bits of cnt / r.
- Exactly one of {acc, div, wr_norm, fifo_ext_rd} is high in any cycle, or none.
- Busy length with ofifo_valid already high: COL + N_Q + COL + 1 + N_Q + WAIT_CYC + N_Q + 5·N_Q + 1. Defaults: 98 cycles.

Optional Feature:
- Macro: FULLCHIP_SEQ_CTRL_PERF_EN.
- Defined:
  - adds output `perf_cycles` [15:0]
  - cleared when start is accepted; increments every busy cycle; saturates at 16'hFFFF
  - holds its value in IDLE; reset value 0
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then idle, start=0 for 20 cycles → busy=0, inst=0, core1_en=core2_en=0, done never pulses.
- One start pulse with ofifo_valid tied 1 (defaults):
  - done at busy cycle 98
  - kmem_wr high for cycles 1-8 with qkmem_add 0..7
  - execute high for 8 consecutive cycles
  - exactly 8 each of acc, fifo_ext_rd, div and wr_norm
- ofifo_valid held 0 until 40 cycles after entering WAIT → DRAIN starts the cycle after ofifo_valid rises; total busy = 98 + 24.
- Reset asserted during NORM row 3 → all outputs 0 immediately, state IDLE, no done; a following start runs a full 98-cycle tile.
- start re-pulsed during EXEC and in the DONE cycle → ignored; only one tile runs, busy falls after DONE.
- With FULLCHIP_SEQ_CTRL_PERF_EN defined → perf_cycles reads 98 after a default tile and holds until the next accepted start.
